// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
// SPI slave endpoint. sck/ssn/mosi are oversampled in the clk_i domain through
// SYNC_STAGES-deep synchronizers; all four CPOL/CPHA modes, MSB first.
// A single-entry TX holding register feeds the shifter. When it is empty at a
// load point, DEFAULT_TX is shifted out and tx_underrun_o pulses.
//
// Optional build macro: SPI_SLV_RX_HOLD_EN
//   defined   : adds rx_ack_i / rx_overrun_o. rx_valid_o becomes a level that
//               is held until rx_ack_i. rx_overrun_o is sticky.
//   undefined : rx_valid_o is a one-cycle pulse.
//
// Ports
//   clk_i, rstn_i          system clock, async active-low reset
//   cpol_i, cpha_i         SPI mode, captured at frame start
//   sck_i, ssn_i, mosi_i   SPI pins from the master (asynchronous)
//   miso_o, miso_oe_o      SPI data to the master and its output enable
//   tx_valid_i/tx_ready_o/tx_data_i    TX byte handshake
//   rx_valid_o/rx_data_o               received byte
//   tx_underrun_o          pulse when DEFAULT_TX was loaded
// -----------------------------------------------------------------------------
module spi_slave_core #(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] DEFAULT_TX  = {DATA_W{1'b1}},
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              sck_i,
    input  logic              ssn_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              rx_valid_o,
    output logic [DATA_W-1:0] rx_data_o,
`ifdef SPI_SLV_RX_HOLD_EN
    input  logic              rx_ack_i,
    output logic              rx_overrun_o,
`endif
    output logic              tx_underrun_o
);

    localparam int              CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    state_e                  state_q;
    logic [SYNC_STAGES-1:0]  sck_sync_q;
    logic [SYNC_STAGES-1:0]  ssn_sync_q;
    logic [SYNC_STAGES-1:0]  mosi_sync_q;
    logic                    sck_prev_q;
    logic                    ssn_prev_q;
    logic                    cpol_q;
    logic                    cpha_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [DATA_W-1:0]       rx_shift_q;
    logic [DATA_W-1:0]       tx_shift_q;
    logic [DATA_W-1:0]       rx_data_q;
    logic                    rx_valid_q;
    logic                    miso_q;
    logic                    miso_oe_q;
    logic                    underrun_q;
    logic                    tx_ready_q;
    logic [DATA_W-1:0]       hold_q;
`ifdef SPI_SLV_RX_HOLD_EN
    logic                    rx_overrun_q;
`endif

    logic                    sck_s;
    logic                    ssn_s;
    logic                    mosi_s;
    logic                    sck_rise_s;
    logic                    sck_fall_s;
    logic                    ssn_fall_s;
    logic                    sample_s;
    logic                    shift_s;
    logic                    load_evt_s;
    logic [DATA_W-1:0]       load_byte_s;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign ssn_s  = ssn_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign miso_o        = miso_q;
    assign miso_oe_o     = miso_oe_q;
    assign tx_ready_o    = tx_ready_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_data_o     = rx_data_q;
    assign tx_underrun_o = underrun_q;
`ifdef SPI_SLV_RX_HOLD_EN
    assign rx_overrun_o  = rx_overrun_q;
`endif

    // Synchronizers for the asynchronous SPI pins plus edge-detect history.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sck_sync_q  <= '0;
            ssn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ssn_prev_q  <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], ssn_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sck_prev_q  <= sck_s;
            ssn_prev_q  <= ssn_s;
        end
    end

    // Edge roles and shifter load events.
    always_comb begin
        sck_rise_s  = sck_s & ~sck_prev_q;
        sck_fall_s  = ~sck_s & sck_prev_q;
        ssn_fall_s  = ssn_prev_q & ~ssn_s;
        sample_s    = 1'b0;
        shift_s     = 1'b0;
        load_evt_s  = 1'b0;
        load_byte_s = tx_ready_q ? DEFAULT_TX : hold_q;
        if (state_q == ACTIVE) begin
            // Leading edge leaves the idle level cpol; cpha picks which edge samples.
            if (cpha_q) begin
                sample_s = cpol_q ? sck_rise_s : sck_fall_s;
                shift_s  = cpol_q ? sck_fall_s : sck_rise_s;
            end else begin
                sample_s = cpol_q ? sck_fall_s : sck_rise_s;
                shift_s  = cpol_q ? sck_rise_s : sck_fall_s;
            end
            // Reload for a following byte only while the frame continues.
            load_evt_s = sample_s & (bit_cnt_q == CNT_LAST) & ~ssn_s;
        end else begin
            load_evt_s = ssn_fall_s;
        end
    end

    // TX holding register; tx_ready_q doubles as its empty flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_ready_q <= 1'b1;
            hold_q     <= '0;
        end else if (load_evt_s && !tx_ready_q) begin
            tx_ready_q <= 1'b1;
        end else if (tx_valid_i && tx_ready_q) begin
            hold_q     <= tx_data_i;
            tx_ready_q <= 1'b0;
        end else begin
            tx_ready_q <= tx_ready_q;
        end
    end

    // Frame FSM with shift registers and all registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef SPI_SLV_RX_HOLD_EN
            rx_overrun_q <= 1'b0;
`endif
        end else begin
`ifdef SPI_SLV_RX_HOLD_EN
            if (rx_ack_i) begin
                rx_valid_q   <= 1'b0;
                rx_overrun_q <= 1'b0;
            end
`else
            rx_valid_q <= 1'b0;
`endif
            underrun_q <= load_evt_s & tx_ready_q;
            case (state_q)
                IDLE: begin
                    miso_oe_q <= 1'b0;
                    if (ssn_fall_s) begin
                        state_q   <= ACTIVE;
                        miso_oe_q <= 1'b1;
                        cpol_q    <= cpol_i;
                        cpha_q    <= cpha_i;
                        bit_cnt_q <= '0;
                        // cpha=0: the master samples the MSB on the very first edge.
                        if (cpha_i) begin
                            tx_shift_q <= load_byte_s;
                            miso_q     <= 1'b0;
                        end else begin
                            tx_shift_q <= {load_byte_s[DATA_W-2:0], 1'b0};
                            miso_q     <= load_byte_s[DATA_W-1];
                        end
                    end
                end
                ACTIVE: begin
                    if (sample_s) begin
                        rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
                        if (bit_cnt_q == CNT_LAST) begin
                            bit_cnt_q  <= '0;
                            rx_data_q  <= {rx_shift_q[DATA_W-2:0], mosi_s};
                            rx_valid_q <= 1'b1;
`ifdef SPI_SLV_RX_HOLD_EN
                            if (rx_valid_q && !rx_ack_i) begin
                                rx_overrun_q <= 1'b1;
                            end
`endif
                            // Full byte: its MSB goes out on the next shift edge.
                            if (!ssn_s) begin
                                tx_shift_q <= load_byte_s;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (shift_s) begin
                        miso_q     <= tx_shift_q[DATA_W-1];
                        tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                    // A partial byte is simply abandoned when ssn rises.
                    if (ssn_s) begin
                        state_q   <= IDLE;
                        miso_oe_q <= 1'b0;
                        miso_q    <= 1'b0;
                    end else begin
                        miso_oe_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    miso_oe_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
